tt_vector_checker: RTL and testbench

- Parametrised, synthesisable stimulus player and response checker for a `tt_um_*` user project.
- Buffers input vectors, drives them onto the DUT's `ui_in`/`uio_in` one per cycle, and waits a configurable pipeline latency.
- Compares the DUT's `uo_out` against an expected value under a mask, then counts and locates mismatches.
- Replaces bare pin-wiggling wrappers around the user project; usable in simulation and on FPGA bring-up boards.

---
 rtl/tt_vec_pkg.sv | 34 +++
 rtl/tt_vector_checker_if.sv | 35 +++
 rtl/tt_vec_fifo.sv | 53 +++++
 rtl/tt_vector_checker.sv | 202 ++++++++++++++++++++
 tb/tb_tt_vector_checker.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/tt_vec_pkg.sv
// Shared types for the tt_um stimulus player / response checker.
// Payload structs are sized by VEC_IO_W; the checker's IO_W must match it.
package tt_vec_pkg;

    localparam int          VEC_IO_W = 8;
    localparam logic [15:0] ERR_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_e;

    typedef struct packed {
        logic [VEC_IO_W-1:0] ui;
        logic [VEC_IO_W-1:0] uio;
        logic [VEC_IO_W-1:0] exp;
        logic [VEC_IO_W-1:0] mask;
        logic                last;
    } vec_t;

    typedef struct packed {
        logic [VEC_IO_W-1:0] exp;
        logic [VEC_IO_W-1:0] mask;
        logic [15:0]         idx;
        logic                valid;
    } pipe_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == ERR_SAT) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/tt_vector_checker_if.sv
// Vector push handshake between a stimulus source and the checker.
// The master offers a vector; the slave raises vec_ready when it has room.
interface tt_vector_checker_if #(
    parameter int IO_W = tt_vec_pkg::VEC_IO_W
);

    logic            vec_valid;
    logic            vec_ready;
    logic [IO_W-1:0] vec_ui;
    logic [IO_W-1:0] vec_uio;
    logic [IO_W-1:0] vec_exp;
    logic [IO_W-1:0] vec_mask;
    logic            vec_last;

    modport master (
        output vec_valid,
        output vec_ui,
        output vec_uio,
        output vec_exp,
        output vec_mask,
        output vec_last,
        input  vec_ready
    );

    modport slave (
        input  vec_valid,
        input  vec_ui,
        input  vec_uio,
        input  vec_exp,
        input  vec_mask,
        input  vec_last,
        output vec_ready
    );

endinterface

// File: rtl/tt_vec_fifo.sv
// Synchronous show-ahead FIFO; an extra pointer bit separates full from empty.
// Pushes while full and pops while empty are ignored.
module tt_vec_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wptr_q, wptr_d;
    logic [AW:0]  rptr_q, rptr_d;
    logic         do_push;
    logic         do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) wptr_d = wptr_q + 1'b1;
        if (do_pop)  rptr_d = rptr_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/tt_vector_checker.sv
// Plays buffered vectors into a tt_um user project and checks uo_out
// after a configurable latency, counting and locating mismatches.
module tt_vector_checker
    import tt_vec_pkg::*;
#(
    parameter int IO_W    = VEC_IO_W,
    parameter int DEPTH   = 16,
    parameter int MAX_LAT = 7,
    parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    tt_vector_checker_if.slave  vec,
    input  logic [LAT_W-1:0]    lat_cfg,
    input  logic                start,
    output logic [IO_W-1:0]     dut_ui_in,
    output logic [IO_W-1:0]     dut_uio_in,
    input  logic [IO_W-1:0]     dut_uo_out,
    output logic                busy,
    output logic                done,
    output logic [15:0]         err_count,
    output logic [15:0]         first_err_idx,
    output logic                err_sticky
);

    state_e           state_q;
    logic             busy_q;
    logic             done_q;
    logic [LAT_W-1:0] lat_q;
    logic [LAT_W-1:0] drain_q;
    logic [LAT_W-1:0] lat_clamp;

    vec_t        push_vec;
    vec_t        head;
    logic        full;
    logic        empty;
    logic        pop;
    logic        launch;

    logic [IO_W-1:0] ui_q, ui_d;
    logic [IO_W-1:0] uio_q, uio_d;
    logic [15:0]     idx_q, idx_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [15:0]     first_q, first_d;
    logic            sticky_q, sticky_d;

    pipe_t pipe_q [MAX_LAT+1];
    pipe_t pipe_in;
    pipe_t tap;
    logic  mismatch;

    assign push_vec = '{
        ui:   vec.vec_ui,
        uio:  vec.vec_uio,
        exp:  vec.vec_exp,
        mask: vec.vec_mask,
        last: vec.vec_last
    };

    assign vec.vec_ready = !full;

    tt_vec_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(vec_t))
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (vec.vec_valid),
        .wdata_i (push_vec),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    assign pop    = (state_q == RUN) && !empty;
    assign launch = (state_q == IDLE) && start;

    assign lat_clamp = (lat_cfg > LAT_W'(MAX_LAT)) ?
                       LAT_W'(MAX_LAT) : lat_cfg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            lat_q   <= '0;
            drain_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        lat_q   <= lat_clamp;
                    end
                end
                RUN: begin
                    if (pop && head.last) begin
                        state_q <= DRAIN;
                        drain_q <= lat_q;
                    end
                end
                DRAIN: begin
                    // last compare happens in the cycle drain_q reaches zero
                    if (drain_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        pipe_in = '0;
        if (pop) begin
            pipe_in.exp   = head.exp;
            pipe_in.mask  = head.mask;
            pipe_in.idx   = idx_q;
            pipe_in.valid = 1'b1;
        end
    end

    // stage 0 is already aligned with the cycle the vector hits ui_in
    assign tap      = pipe_q[lat_q];
    assign mismatch = tap.valid &&
                      |((dut_uo_out ^ tap.exp) & tap.mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= MAX_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= pipe_in;
            for (int i = 1; i <= MAX_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    always_comb begin
        ui_d     = ui_q;
        uio_d    = uio_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        first_d  = first_q;
        sticky_d = sticky_q;
        if (pop) begin
            ui_d  = head.ui;
            uio_d = head.uio;
        end
        if (launch) begin
            idx_d    = '0;
            cnt_d    = '0;
            first_d  = '0;
            sticky_d = 1'b0;
        end else begin
            if (pop) idx_d = idx_q + 16'd1;
            if (mismatch) begin
                cnt_d = sat_inc(cnt_q);
                if (!sticky_q) begin
                    first_d  = tap.idx;
                    sticky_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ui_q     <= '0;
            uio_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            first_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            ui_q     <= ui_d;
            uio_q    <= uio_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            first_q  <= first_d;
            sticky_q <= sticky_d;
        end
    end

    assign dut_ui_in     = ui_q;
    assign dut_uio_in    = uio_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = cnt_q;
    assign first_err_idx = first_q;
    assign err_sticky    = sticky_q;

endmodule

// File: tb/tb_tt_vector_checker.sv
// Scoreboard bench: each run queues its expected error summary and a
// monitor checks it against the outputs whenever done pulses.
module tb_tt_vector_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  lat_cfg;
    logic        start;
    logic [7:0]  dut_ui_in;
    logic [7:0]  dut_uio_in;
    logic [7:0]  dut_uo_out;
    logic        busy;
    logic        done;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic        err_sticky;

    always #5 clk = ~clk;

    tt_vector_checker_if #(.IO_W(8)) vif ();

    tt_vector_checker #(
        .IO_W    (8),
        .DEPTH   (16),
        .MAX_LAT (7)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vec           (vif),
        .lat_cfg       (lat_cfg),
        .start         (start),
        .dut_ui_in     (dut_ui_in),
        .dut_uio_in    (dut_uio_in),
        .dut_uo_out    (dut_uo_out),
        .busy          (busy),
        .done          (done),
        .err_count     (err_count),
        .first_err_idx (first_err_idx),
        .err_sticky    (err_sticky)
    );

    // user project model: registered pass-through or combinational invert
    logic       inv_mode;
    logic [7:0] pt_q;
    always @(posedge clk) pt_q <= dut_ui_in;
    assign dut_uo_out = inv_mode ? ~dut_ui_in : pt_q;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] cnt;
        logic [15:0] idx;
        logic        sticky;
        string       tag;
    } res_t;

    res_t exp_q[$];
    int   done_pulses = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    always @(negedge clk) begin
        res_t r;
        if (rst === 1'b0 && done === 1'b1) begin
            done_pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got 1 want 0");
            end else begin
                r = exp_q.pop_front();
                check({r.tag, "_cnt"}, err_count, r.cnt);
                check({r.tag, "_idx"}, first_err_idx, r.idx);
                check({r.tag, "_sticky"}, err_sticky, r.sticky);
            end
        end
    end

    task automatic push(input logic [7:0] ui, input logic [7:0] uio,
                        input logic [7:0] ex, input logic [7:0] mk,
                        input logic last);
        int n;
        n = 0;
        while (vif.vec_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("push_ready");
        vif.vec_ui    = ui;
        vif.vec_uio   = uio;
        vif.vec_exp   = ex;
        vif.vec_mask  = mk;
        vif.vec_last  = last;
        vif.vec_valid = 1'b1;
        @(negedge clk);
        vif.vec_valid = 1'b0;
    endtask

    task automatic start_run(input logic [2:0] lat, input logic [15:0] cnt,
                             input logic [15:0] idx, input logic sticky,
                             input string tag);
        res_t r;
        r.cnt    = cnt;
        r.idx    = idx;
        r.sticky = sticky;
        r.tag    = tag;
        exp_q.push_back(r);
        lat_cfg = lat;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // n counts clock edges after the one that sampled start
    task automatic wait_done(input int n0, input int want_cyc,
                             input string tag);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) fail({tag, "_done"});
        else check({tag, "_cycles"}, n, want_cyc);
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        rst           = 1'b1;
        start         = 1'b0;
        lat_cfg       = '0;
        inv_mode      = 1'b0;
        vif.vec_valid = 1'b0;
        vif.vec_ui    = '0;
        vif.vec_uio   = '0;
        vif.vec_exp   = '0;
        vif.vec_mask  = '0;
        vif.vec_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cnt", err_count, 0);
        check("rst_idx", first_err_idx, 0);
        check("rst_sticky", err_sticky, 0);
        check("rst_ui", dut_ui_in, 0);
        check("rst_ready", vif.vec_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        // clean pass-through run
        for (int i = 1; i <= 4; i++)
            push(8'(i), 8'h00, 8'(i), 8'hFF, i == 4);
        start_run(3'd1, 16'd0, 16'd0, 1'b0, "pass");
        wait_done(0, 6, "pass");

        // third vector (idx 2) fails in its low nibble
        push(8'h01, 8'h00, 8'h01, 8'hFF, 1'b0);
        push(8'h02, 8'h00, 8'h02, 8'hFF, 1'b0);
        push(8'h03, 8'h00, 8'hFF, 8'h0F, 1'b0);
        push(8'h04, 8'h00, 8'h04, 8'hFF, 1'b1);
        start_run(3'd1, 16'd1, 16'd2, 1'b1, "onebad");
        wait_done(0, 6, "onebad");

        push(8'h01, 8'h00, 8'h01, 8'hFF, 1'b0);
        push(8'h02, 8'h00, 8'h02, 8'hFF, 1'b0);
        push(8'h03, 8'h00, 8'hFF, 8'h00, 1'b0);
        push(8'h04, 8'h00, 8'h04, 8'hFF, 1'b1);
        start_run(3'd1, 16'd0, 16'd0, 1'b0, "masked");
        wait_done(0, 6, "masked");

        // fill the FIFO, then offer a rejected 17th vector
        for (int i = 0; i < 16; i++)
            push(8'(8'h10 + i), 8'(i), 8'(8'h10 + i), 8'hFF, i == 15);
        check("full_ready", vif.vec_ready, 0);
        vif.vec_ui    = 8'hAA;
        vif.vec_exp   = 8'h55;
        vif.vec_mask  = 8'hFF;
        vif.vec_last  = 1'b1;
        vif.vec_valid = 1'b1;
        repeat (2) @(negedge clk);
        vif.vec_valid = 1'b0;
        check("full_ready_hold", vif.vec_ready, 0);
        start_run(3'd1, 16'd0, 16'd0, 1'b0, "full");
        check("ready_first_pop", vif.vec_ready, 0);
        @(negedge clk);
        check("ready_after_pop", vif.vec_ready, 1);
        wait_done(1, 18, "full");

        // combinational inverter at lat 0
        inv_mode = 1'b1;
        push(8'h11, 8'h00, 8'hEE, 8'hFF, 1'b0);
        push(8'h22, 8'h00, 8'hDD, 8'hFF, 1'b0);
        push(8'h33, 8'h00, 8'hCC, 8'hFF, 1'b0);
        push(8'h44, 8'h00, 8'hBB, 8'hFF, 1'b1);
        start_run(3'd0, 16'd0, 16'd0, 1'b0, "inv0");
        wait_done(0, 5, "inv0");

        // at lat 2 vector k sees vector k+2 on the pins; the last one
        // sees its own value still held, so only three mismatch
        push(8'h11, 8'h00, 8'hEE, 8'hFF, 1'b0);
        push(8'h22, 8'h00, 8'hDD, 8'hFF, 1'b0);
        push(8'h33, 8'h00, 8'hCC, 8'hFF, 1'b0);
        push(8'h44, 8'h00, 8'hBB, 8'hFF, 1'b1);
        start_run(3'd2, 16'd3, 16'd0, 1'b1, "inv2");
        wait_done(0, 7, "inv2");
        inv_mode = 1'b0;

        // reset in the middle of a run
        push(8'h30, 8'h00, 8'h00, 8'hFF, 1'b0);
        for (int i = 1; i < 4; i++)
            push(8'(8'h30 + i), 8'h00, 8'(8'h30 + i), 8'hFF, 1'b0);
        for (int i = 4; i < 8; i++)
            push(8'(8'h30 + i), 8'h00, ~8'(8'h30 + i), 8'hFF, i == 7);
        lat_cfg = 3'd1;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        n = 0;
        while (dut_ui_in !== 8'h33 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (n >= 30) fail("rst_wait_vec3");
        check("pre_rst_cnt", err_count, 1);
        p0  = done_pulses;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_cnt", err_count, 0);
        check("mid_rst_sticky", err_sticky, 0);
        check("mid_rst_ui", dut_ui_in, 0);
        check("mid_rst_ready", vif.vec_ready, 1);
        check("mid_rst_done", done, 0);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("mid_rst_no_done", done_pulses - p0, 0);
        check("post_rst_cnt", err_count, 0);
        check("post_rst_busy", busy, 0);

        // stale FIFO or pipe content would disturb this run
        push(8'h5A, 8'h00, 8'h5A, 8'hFF, 1'b1);
        start_run(3'd1, 16'd0, 16'd0, 1'b0, "after_rst");
        wait_done(0, 3, "after_rst");

        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
